// File: rtl/fir_coeff_mac.sv
// Sequential multiply-accumulate FIR stage: one tap per cycle against an external coefficient
// lookup, with floor rescale and saturation onto a valid/ready output.
module fir_coeff_mac #(
  parameter int unsigned N_TAPS    = 4,
  parameter int unsigned WIDTH     = 18,
  parameter int          IN_EXP    = -12,
  parameter int          COEFF_EXP = -12,
  parameter int          OUT_EXP   = -12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [$clog2(N_TAPS)-1:0]   coeff_addr,
  input  logic signed [WIDTH-1:0]     coeff_data,
  output logic signed [WIDTH-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned KW    = $clog2(N_TAPS);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned AW    = PW + KW;
  localparam int          SHIFT = OUT_EXP - (IN_EXP + COEFF_EXP);

  localparam logic [KW-1:0] LAST_TAP = KW'(N_TAPS - 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  if (N_TAPS < 2) begin : g_bad_taps
    $error("fir_coeff_mac: N_TAPS must be at least 2");
  end
  if (SHIFT < 0) begin : g_bad_exp
    $error("fir_coeff_mac: OUT_EXP must be >= IN_EXP + COEFF_EXP");
  end

  logic [1:0]              state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] x_q [N_TAPS];
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc_sum;
  logic signed [AW-1:0]    scaled;
  logic signed [WIDTH-1:0] result;

  // in_ready is gated by rst so nothing is accepted in the cycle reset is applied.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign coeff_addr = (state_q == ACCUM) ? k_q : '0;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;

  always_comb begin
    prod    = PW'(coeff_data) * PW'(x_q[k_q]);
    acc_sum = acc_q + AW'(prod);
    // Arithmetic shift floors toward minus infinity; the wide accumulator cannot overflow.
    scaled  = acc_sum >>> SHIFT;
    if (scaled > SAT_MAX) begin
      result = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      result = SAT_MIN[WIDTH-1:0];
    end else begin
      result = scaled[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        if (k_q == LAST_TAP) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Delay line: x_q[0] holds the newest sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_TAPS); i++) begin
        x_q[i] <= '0;
      end
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int i = 1; i < int'(N_TAPS); i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

endmodule

// File: doc/fir_coeff_mac.md
# fir_coeff_mac

Sequential multiply-accumulate FIR stage that consumes the coefficient table one entry per cycle. For each accepted input sample it shifts a delay line, sweeps `coeff_addr` across all taps and accumulates `coeff_data * x[k]` in signed fixed point. It then presents the rescaled, saturated result on a valid/ready output. It sits directly downstream of the combinational coefficient lookup and drives that lookup's address.

## Interface
- `N_TAPS`, default 4: tap count (≥2). It sets the delay-line depth and the coefficient address range.
- `WIDTH`, default 18: signed width of the input sample, the coefficient and the output.
- `IN_EXP`, default -12: fixed-point exponent of `in_data` (value = code·2^IN_EXP).
- `COEFF_EXP`, default -12: exponent of `coeff_data`.
- `OUT_EXP`, default -12: exponent of `out_data`. It must satisfy OUT_EXP ≥ IN_EXP+COEFF_EXP.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_data`, in, WIDTH: signed input sample.
- `in_valid`, in, 1: the input sample is valid.
- `in_ready`, out, 1: the block can accept a sample.
- `coeff_addr`, out, $clog2(N_TAPS): address of the coefficient table.
- `coeff_data`, in, WIDTH: signed coefficient, combinationally valid in the same cycle as `coeff_addr`.
- `out_data`, out, WIDTH: signed filter output.
- `out_valid`, out, 1: the output is valid.
- `out_ready`, in, 1: the downstream stage accepts the output.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE
  - `in_ready`=1.
  - On `in_valid && in_ready`, the block shifts the delay line: x[0]←in_data and x[k]←x[k-1]. It clears the accumulator and sets the tap counter k=0, then enters ACCUM.
- ACCUM
  - `coeff_addr`=k.
  - Each cycle: acc ← acc + coeff_data·x[k].
  - When k=N_TAPS-1, the block latches the rescaled result into `out_data`, sets `out_valid`=1 and enters HOLD.
  - Otherwise k←k+1.
- HOLD
  - `out_data` and `out_valid` are held stable until `out_ready`=1.
  - On the handshake, `out_valid`←0 and the state returns to IDLE.
- `in_ready`=0 in ACCUM and HOLD. Inputs presented in those states are not consumed and are not dropped; the upstream stage holds them.
- Arithmetic:
  - The product is 2·WIDTH bits at exponent IN_EXP+COEFF_EXP.
  - The accumulator is 2·WIDTH+$clog2(N_TAPS) bits signed, sign-extended, and never wraps.
  - Rescale uses an arithmetic right shift by OUT_EXP−(IN_EXP+COEFF_EXP), which floors the result.
  - The rescaled value then saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `coeff_addr` outside ACCUM = 0.

## Timing
- Reset, while `rst`=1 at a clock edge:
  - state=IDLE.
  - Delay line, acc and k = 0.
  - `out_data`=0, `out_valid`=0, `coeff_addr`=0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after deassertion.
- Reset mid-ACCUM or mid-HOLD aborts the operation. The partial result is discarded and no output is produced.
- Latency:
  - Input handshake at edge 0.
  - ACCUM occupies edges 1..N_TAPS.
  - `out_valid`=1 after edge N_TAPS, which is 4 cycles with defaults.
- Throughput with `out_ready` tied to 1 is one sample per N_TAPS+2 cycles.
- With `out_ready`=0, HOLD persists indefinitely and `out_data` does not change.
- The delay line is initialised to zeros. The first N_TAPS−1 outputs therefore see zero history.

## Test plan
Defaults apply throughout. The coefficient table returns {4915, 13926, 22938, 31949} (1.2, 3.4, 5.6, 7.8 at 2^-12) for addresses 0–3.

- **Impulse:** after reset, inputs 4096, 0, 0, 0 -> outputs 4915, 13926, 22938, 31949. `coeff_addr` steps 0,1,2,3 in each ACCUM.
- **Step:** inputs of 4096 held for 6 samples -> outputs 4915, 18841, 41779, 73728, 73728, 73728.
- **Saturation:**
  - 4 samples of 131071 -> 4th output 131071.
  - After reset, 4 samples of −131072 -> 4th output −131072.
- **Backpressure:** `out_ready`=0 for 10 cycles in HOLD -> `out_valid` and `out_data` stay stable and `in_ready`=0 throughout. `out_ready`=1 -> one handshake, then IDLE with `in_ready`=1 in the next cycle.
- **Reset mid-ACCUM:** assert `rst` when k=2 -> next cycle all outputs are at reset values. The next sample 4096 yields 4915, confirming the delay line was cleared.
- **Input stall:** `in_valid` toggled randomly with `out_ready` randomly deasserted -> the output sequence matches a reference model of the convolution with floor and saturation, with no lost or duplicated samples.
